ssm_scan_sequencer: RTL
=======================

SSM_SCAN_SEQUENCER -- requirements
Module: ssm_scan_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data word width of y results.
REQ-002 SHALL have parameter H, default 24, meaning head count.
REQ-003 SHALL have parameter P, default 64, meaning head dimension.
REQ-004 SHALL have parameter N, default 128, meaning state dimension.
REQ-005 SHALL have parameter N_TILE, default 16, meaning state elements per tile.
REQ-006 SHALL have parameter H_TILE, default 1, meaning head blocking factor.
REQ-007 SHALL have parameter P_TILE, default 1, meaning P blocking factor.
REQ-008 SHALL have parameter DEPTH, default 8, meaning max outstanding (h,p) groups; power of 2.
REQ-009 SHALL derive HW=max(1,clog2(H)), PW=max(1,clog2(P)), TW=max(1,clog2(N/N_TILE)), AW=max(1,clog2(H*P)).
REQ-010 clk  in  1  sole clock, all state on rising edge.
REQ-011 rst  in  1  reset, asynchronous, active-high.
REQ-012 start_i  in  1  begin full scan; honoured only in IDLE.
REQ-013 busy_o  out  1  high in RUN and DRAIN.
REQ-014 done_o  out  1  one-cycle pulse at scan completion.
REQ-015 cmd_valid_o / cmd_ready_i  out / in  1 / 1  tile command handshake to SSM datapath.
REQ-016 cmd_h_o, cmd_p_o, cmd_t_o  out  HW, PW, TW  head, P index, tile index of current command.
REQ-017 cmd_first_o / cmd_last_o  out  1 / 1  command is tile 0 / tile N/N_TILE-1 of its group.
REQ-018 y_i / y_valid_i  in  DW / 1  completed group result, in group issue order.
REQ-019 wr_en_o, wr_addr_o, wr_data_o  out  1, AW, DW  result memory write port.
REQ-020 err_o  out  1  sticky: y_valid_i received with no outstanding group.

Function
REQ-021 SHALL reject at elaboration any H%H_TILE, P%P_TILE or N%N_TILE nonzero, or non-power-of-2 DEPTH.
REQ-022 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_i; RUN->DRAIN on acceptance of final command; DRAIN->DONE when tag FIFO empty and no write pending; DONE->IDLE after one cycle.
REQ-023 SHALL on IDLE->RUN zero all scan counters and clear err_o.
REQ-024 SHALL issue commands in order h_blk, p_blk, h_rel, p_rel, t (t innermost), h=h_blk+h_rel, p=p_blk+p_rel.
REQ-025 SHALL advance command only on cmd_valid_o & cmd_ready_i; all cmd_* fields SHALL be held stable while cmd_valid_o & !cmd_ready_i.
REQ-026 SHALL push tag h*P+p into a DEPTH-entry FIFO on acceptance of each cmd_first_o command.
REQ-027 SHALL hold cmd_valid_o low for a first-tile command while the tag FIFO holds DEPTH entries; non-first tiles never stall on FIFO state.
REQ-028 SHALL pop one tag per y_valid_i and drive wr_en_o=1, wr_addr_o=tag, wr_data_o=y_i exactly one cycle later.
REQ-029 SHALL handle simultaneous push and pop in one cycle with unchanged count.
REQ-030 SHALL on y_valid_i with empty FIFO (any state) drop the data, assert no write, and set err_o.
REQ-031 SHALL ignore start_i outside IDLE.
REQ-032 SHALL assert done_o in DONE only, one cycle after the final write.

Reset
REQ-033 SHALL on rst immediately force IDLE, empty FIFO, zero counters, and all outputs 0, including mid-scan; a following start_i SHALL rescan from (0,0,0).

Verification (H=2,P=4,N=32,N_TILE=16,H_TILE=2,P_TILE=2,DEPTH=4)
REQ-034 cmd_ready_i=1, y returned 5 cycles after each cmd_last -> 16 commands, groups (0,0),(0,1),(1,0),(1,1),(0,2),(0,3),(1,2),(1,3); wr_addr_o 0,1,4,5,2,3,6,7; done_o single pulse.
REQ-035 cmd_ready_i toggling 1010... -> each command held until accepted; same 16-command sequence, no duplicates or skips.
REQ-036 no y returned -> exactly 8 commands accepted, then cmd_valid_o=0 with first tile of (0,2) pending; one y_valid_i -> write addr 0, (0,2) issued.
REQ-037 y_valid_i=1, y_i=16'h1234 in IDLE -> wr_en_o stays 0, err_o=1; next start_i -> err_o=0.
REQ-038 rst pulse after 5 accepted commands -> outputs 0 at once; restart yields first command (0,0,0) and full REQ-034 sequence.

Source files
------------

// File: rtl/ssm_scan_sequencer.sv
// Scan sequencer for an SSM datapath: walks every (h,p,tile) command in blocked order,
// tracks outstanding groups in a tag FIFO and writes returned y results back by tag.
module ssm_scan_sequencer #(
  parameter int DW     = 16,
  parameter int H      = 24,
  parameter int P      = 64,
  parameter int N      = 128,
  parameter int N_TILE = 16,
  parameter int H_TILE = 1,
  parameter int P_TILE = 1,
  parameter int DEPTH  = 8,
  parameter int HW     = (H > 1) ? $clog2(H) : 1,
  parameter int PW     = (P > 1) ? $clog2(P) : 1,
  parameter int TW     = ((N / N_TILE) > 1) ? $clog2(N / N_TILE) : 1,
  parameter int AW     = ((H * P) > 1) ? $clog2(H * P) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          cmd_valid_o,
  input  logic          cmd_ready_i,
  output logic [HW-1:0] cmd_h_o,
  output logic [PW-1:0] cmd_p_o,
  output logic [TW-1:0] cmd_t_o,
  output logic          cmd_first_o,
  output logic          cmd_last_o,
  input  logic [DW-1:0] y_i,
  input  logic          y_valid_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          err_o
);

  localparam int NT   = N / N_TILE;
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = PTRW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TW-1:0]   T_LAST     = TW'(NT - 1);
  localparam logic [HW-1:0]   H_REL_LAST = HW'(H_TILE - 1);
  localparam logic [HW-1:0]   H_BLK_LAST = HW'(H - H_TILE);
  localparam logic [HW-1:0]   H_STEP     = HW'(H_TILE);
  localparam logic [PW-1:0]   P_REL_LAST = PW'(P_TILE - 1);
  localparam logic [PW-1:0]   P_BLK_LAST = PW'(P - P_TILE);
  localparam logic [PW-1:0]   P_STEP     = PW'(P_TILE);
  localparam logic [AW-1:0]   P_MUL      = AW'(P);
  localparam logic [PTRW-1:0] PTR_LAST   = PTRW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL   = CW'(DEPTH);

  generate
    if ((H % H_TILE) != 0) begin : g_bad_h_tile
      $error("H must be a multiple of H_TILE");
    end
    if ((P % P_TILE) != 0) begin : g_bad_p_tile
      $error("P must be a multiple of P_TILE");
    end
    if ((N % N_TILE) != 0) begin : g_bad_n_tile
      $error("N must be a multiple of N_TILE");
    end
    if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of 2");
    end
  endgenerate

  logic [1:0]      state_q, state_d;
  logic [HW-1:0]   h_blk_q, h_blk_d, h_rel_q, h_rel_d;
  logic [PW-1:0]   p_blk_q, p_blk_d, p_rel_q, p_rel_d;
  logic [TW-1:0]   t_q, t_d;
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   tag_mem_q [DEPTH];
  logic            wr_en_q, err_q, busy_q, done_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;

  logic          in_run_s, t_first_s, t_last_s, fifo_full_s, fifo_empty_s;
  logic          accept_s, push_s, pop_s, final_s, start_scan_s;
  logic [AW-1:0] tag_s;

  assign in_run_s     = (state_q == S_RUN);
  assign t_first_s    = (t_q == {TW{1'b0}});
  assign t_last_s     = (t_q == T_LAST);
  assign fifo_full_s  = (cnt_q == CNT_FULL);
  assign fifo_empty_s = (cnt_q == {CW{1'b0}});
  assign start_scan_s = (state_q == S_IDLE) & start_i;

  // Only a group-opening tile needs a FIFO slot, so only it waits on a full FIFO.
  assign cmd_valid_o = in_run_s & ~(t_first_s & fifo_full_s);
  assign accept_s    = cmd_valid_o & cmd_ready_i;
  assign push_s      = accept_s & t_first_s;
  assign pop_s       = y_valid_i & ~fifo_empty_s;
  assign final_s     = accept_s & t_last_s & (p_rel_q == P_REL_LAST) & (h_rel_q == H_REL_LAST)
                     & (p_blk_q == P_BLK_LAST) & (h_blk_q == H_BLK_LAST);

  assign cmd_h_o     = h_blk_q + h_rel_q;
  assign cmd_p_o     = p_blk_q + p_rel_q;
  assign cmd_t_o     = t_q;
  assign cmd_first_o = in_run_s & t_first_s;
  assign cmd_last_o  = in_run_s & t_last_s;
  assign tag_s       = AW'(cmd_h_o) * P_MUL + AW'(cmd_p_o);

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign err_o     = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (final_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // An empty FIFO means the last pop already produced its write this cycle.
        if (fifo_empty_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    t_d     = t_q;
    p_rel_d = p_rel_q;
    h_rel_d = h_rel_q;
    p_blk_d = p_blk_q;
    h_blk_d = h_blk_q;
    if (start_scan_s) begin
      t_d     = {TW{1'b0}};
      p_rel_d = {PW{1'b0}};
      h_rel_d = {HW{1'b0}};
      p_blk_d = {PW{1'b0}};
      h_blk_d = {HW{1'b0}};
    end else if (accept_s) begin
      if (!t_last_s) begin
        t_d = t_q + TW'(1);
      end else begin
        t_d = {TW{1'b0}};
        if (p_rel_q != P_REL_LAST) begin
          p_rel_d = p_rel_q + PW'(1);
        end else begin
          p_rel_d = {PW{1'b0}};
          if (h_rel_q != H_REL_LAST) begin
            h_rel_d = h_rel_q + HW'(1);
          end else begin
            h_rel_d = {HW{1'b0}};
            if (p_blk_q != P_BLK_LAST) begin
              p_blk_d = p_blk_q + P_STEP;
            end else begin
              p_blk_d = {PW{1'b0}};
              if (h_blk_q != H_BLK_LAST) begin
                h_blk_d = h_blk_q + H_STEP;
              end else begin
                h_blk_d = {HW{1'b0}};
              end
            end
          end
        end
      end
    end else begin
      t_d = t_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= {TW{1'b0}};
      p_rel_q <= {PW{1'b0}};
      h_rel_q <= {HW{1'b0}};
      p_blk_q <= {PW{1'b0}};
      h_blk_q <= {HW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      p_rel_q <= p_rel_d;
      h_rel_q <= h_rel_d;
      p_blk_q <= p_blk_d;
      h_blk_q <= h_blk_d;
      busy_q  <= (state_d == S_RUN) | (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTRW{1'b0}};
      rd_ptr_q <= {PTRW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? {PTRW{1'b0}} : wr_ptr_q + PTRW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? {PTRW{1'b0}} : rd_ptr_q + PTRW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_mem_q[wr_ptr_q] <= tag_s;
    end
  end

  // A y with nothing outstanding is dropped and latched as an error until the next scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= {DW{1'b0}};
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= pop_s;
      if (pop_s) begin
        wr_addr_q <= tag_mem_q[rd_ptr_q];
        wr_data_q <= y_i;
      end
      if (y_valid_i && fifo_empty_s) begin
        err_q <= 1'b1;
      end else if (start_scan_s) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule
